int_issue_select_stage: RTL and testbench
=========================================

// Module: int_issue_select_stage
// PURPOSE
// - Issue-select/register stage between the integer issue queue, the integer ROB-tag replay unit and register read.
// - Each cycle picks one source for both issue slots: queue select, replay FIFO output, or wake-up-stall replay.
// - Registers the chosen pair with one-cycle latency, handling stalls, squashes and branch kills.
// - Registered outputs drive register read and feed back as issue_instr0/1_valid and _pack of the replay unit.
// PARAMETERS
// - CNT_W  16  width of the saturating replay-occupancy performance counter
// PORTS
// - clk                      in   1        core clock
// - rst                      in   1        reset, asynchronous, active-low (asserted when 0)
// - recovery_flush_BCAST     in   branch_flush_t       branch-recovery kill broadcast
// - recovery_stall           in   1        recovery stall; hold the output registers
// - replay_muldiv_stall      in   1        mul/div busy stall; hold the output registers
// - load_wake_up_failed_stall   in  1     speculative load wake-up missed; take wake-stall source
// - load_wake_up_predict_failed in  1     mis-speculated wake-up; squash this cycle's issue
// - replay_issue_first       in   1        replay FIFO has priority over the queue
// - q_issue_instr0/1_valid   in   1 each   issue-queue selected instruction valid, slot 0/1
// - q_issue_instr0/1_pack    in   int_dispatch_pack_t  issue-queue selected payloads
// - rp_issue_instr0/1_valid  in   1 each   replay FIFO output valid
// - rp_issue_instr0/1_pack   in   int_dispatch_pack_t  replay FIFO output payloads
// - ws_issue_instr0/1_valid  in   1 each   wake-up-stall replay valid
// - ws_issue_instr0/1_pack   in   int_dispatch_pack_t  wake-up-stall replay payloads
// - q_issue_grant0/1         out  1 each   queue slot 0/1 consumed this cycle; the queue frees the entry
// - issue_instr0/1_valid     out  1 each   registered issue valid, to register read and the replay unit
// - issue_instr0/1_pack      out  int_dispatch_pack_t  registered issue payloads
// - issue_src                out  2        registered issue_src_e of the current output pair
// - replay_cycle_cnt         out  CNT_W    saturating count of cycles that issued a replay or wake-stall op
// BEHAVIOUR
// - Reset (rst==0, async): issue_instr0/1_valid=0, packs=0, issue_src=ISSUE_SRC_QUEUE, replay_cycle_cnt=0.
// - Source select (combinational, one source for both slots):
//   - WAKESTALL if load_wake_up_failed_stall.
//   - Otherwise REPLAY if replay_issue_first.
//   - Otherwise QUEUE.
// - hold = recovery_stall | replay_muldiv_stall. Priority order: rst > hold > squash > normal capture.
// - Hold:
//   - Packs and issue_src keep their values.
//   - Each valid is cleared if IsBrROBKill(recovery_flush_BCAST, own pack.rob_tag); otherwise kept.
//   - Grants = 0; counter holds.
// - Squash (load_wake_up_predict_failed & ~hold):
//   - Both valids go to 0 next cycle; packs still capture the selected source.
//   - Grants = 0; counter holds.
// - Normal capture:
//   - valid_n <= sel_valid_n & ~IsBrROBKill(recovery_flush_BCAST, sel_pack_n.rob_tag); pack_n <= sel_pack_n.
//   - issue_src <= selected source.
// - Grants: q_issue_grantN = ~hold & ~load_wake_up_predict_failed & (src==QUEUE) & q_issue_instrN_valid.
//   - Combinational, same cycle as selection.
//   - A killed queue op is still granted; its ROB entry is being flushed.
// - Counter: +1 on a normal-capture cycle with src!=QUEUE and (sel_valid0|sel_valid1).
//   - Saturates at all-ones; never wraps.
// - Latency: selection to output valid is exactly 1 cycle; throughput 2 ops/cycle.
// - Simultaneous hold + load_wake_up_failed_stall: hold wins; nothing captured, no grant.
// - A partially valid pair (one slot valid) is legal and passes through unchanged.
// - Reset asserted mid-stall clears all state immediately, independent of clk.
// STRUCTURE
// - Falco_pkg already holds int_dispatch_pack_t, branch_flush_t, rob_tag_t and IsBrROBKill.
// - Add typedef enum logic [1:0] issue_src_e {ISSUE_SRC_QUEUE=0, ISSUE_SRC_REPLAY=1, ISSUE_SRC_WAKESTALL=2} to Falco_pkg.
// - Sub-module int_issue_slot_reg: one per slot, two instances.
//   - Ports: sel valid/pack in, hold, squash, flush in; valid/pack out.
//   - Owns the per-slot kill and hold logic.
// - Source mux, grants and counter live in the top module.
// TESTING
// - Reset: drive rst=0 mid-traffic -> all valids 0, issue_src=0, replay_cycle_cnt=0 with no clk edge needed.
// - Queue path: q valid 1/1 with rob_tag 5/6, no stalls -> grants 1/1; next cycle valid 1/1, tags 5/6, src=QUEUE.
// - Replay priority: replay_issue_first=1, rp tags 3/4, q valid 1/1 -> grants 0/0; output tags 3/4, src=REPLAY; counter +1.
// - Wake-stall vs replay: load_wake_up_failed_stall=1 and replay_issue_first=1, ws0 valid tag 7, ws1 invalid
//   -> output valid 1/0, tag 7, src=WAKESTALL, no grants.
// - Hold + kill: output tags 9/12, recovery_stall=1, flush kills tags >=10 for 3 cycles
//   -> slot0 stays valid with tag 9; slot1 valid drops on the first edge; grants 0; counter frozen.
// - Squash and saturation: load_wake_up_predict_failed=1 with q valid -> grants 0, next valids 0.
//   - Force counter to all-ones with CNT_W=4 and run 3 replay cycles -> counter stays 15.

Source files
------------

// File: rtl/Falco_pkg.sv
// Shared integer-pipe types: dispatch payload, branch-kill broadcast, issue source encoding.
package Falco_pkg;

    localparam int unsigned ROB_TAG_W = 6;
    localparam int unsigned PREG_W    = 6;
    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned IMM_W     = 20;

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        rob_tag_t              rob_tag;
        logic [OPCODE_W-1:0]   opcode;
        logic [PREG_W-1:0]     prd;
        logic [PREG_W-1:0]     prs1;
        logic [PREG_W-1:0]     prs2;
        logic [IMM_W-1:0]      imm;
    } int_dispatch_pack_t;

    // Kill every op whose ROB tag is at or after kill_from.
    typedef struct packed {
        logic     valid;
        rob_tag_t kill_from;
    } branch_flush_t;

    typedef enum logic [1:0] {
        ISSUE_SRC_QUEUE     = 2'd0,
        ISSUE_SRC_REPLAY    = 2'd1,
        ISSUE_SRC_WAKESTALL = 2'd2
    } issue_src_e;

    function automatic logic IsBrROBKill(input branch_flush_t flush, input rob_tag_t tag);
        return flush.valid && (tag >= flush.kill_from);
    endfunction

endpackage

// File: rtl/int_issue_slot_reg.sv
// One issue slot output register: captures the selected op, holds on stall, drops killed ops.
module int_issue_slot_reg
    import Falco_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               sel_valid,
    input  int_dispatch_pack_t sel_pack,
    input  logic               hold,
    input  logic               squash,
    input  branch_flush_t      flush,
    output logic               valid,
    output int_dispatch_pack_t pack
);

    // While held, a resident op can still be killed by a branch flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            pack  <= '0;
        end else if (hold) begin
            valid <= valid & ~IsBrROBKill(flush, pack.rob_tag);
        end else begin
            pack  <= sel_pack;
            valid <= ~squash & sel_valid & ~IsBrROBKill(flush, sel_pack.rob_tag);
        end
    end

endmodule

// File: rtl/int_issue_select_stage.sv
// Integer issue-select stage: picks queue, replay or wake-stall source for both slots and registers it.
module int_issue_select_stage
    import Falco_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  branch_flush_t      recovery_flush_BCAST,
    input  logic               recovery_stall,
    input  logic               replay_muldiv_stall,
    input  logic               load_wake_up_failed_stall,
    input  logic               load_wake_up_predict_failed,
    input  logic               replay_issue_first,
    input  logic               q_issue_instr0_valid,
    input  logic               q_issue_instr1_valid,
    input  int_dispatch_pack_t q_issue_instr0_pack,
    input  int_dispatch_pack_t q_issue_instr1_pack,
    input  logic               rp_issue_instr0_valid,
    input  logic               rp_issue_instr1_valid,
    input  int_dispatch_pack_t rp_issue_instr0_pack,
    input  int_dispatch_pack_t rp_issue_instr1_pack,
    input  logic               ws_issue_instr0_valid,
    input  logic               ws_issue_instr1_valid,
    input  int_dispatch_pack_t ws_issue_instr0_pack,
    input  int_dispatch_pack_t ws_issue_instr1_pack,
    output logic               q_issue_grant0,
    output logic               q_issue_grant1,
    output logic               issue_instr0_valid,
    output logic               issue_instr1_valid,
    output int_dispatch_pack_t issue_instr0_pack,
    output int_dispatch_pack_t issue_instr1_pack,
    output logic [1:0]         issue_src,
    output logic [CNT_W-1:0]   replay_cycle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    issue_src_e         sel_src;
    logic               sel_valid0;
    logic               sel_valid1;
    int_dispatch_pack_t sel_pack0;
    int_dispatch_pack_t sel_pack1;
    logic               hold;
    logic               squash;
    logic               capture;
    issue_src_e         src_r;

    assign hold    = recovery_stall | replay_muldiv_stall;
    assign squash  = load_wake_up_predict_failed & ~hold;
    assign capture = ~hold & ~load_wake_up_predict_failed;

    // One source feeds both slots; wake-stall beats replay beats queue.
    always_comb begin
        sel_src    = ISSUE_SRC_QUEUE;
        sel_valid0 = q_issue_instr0_valid;
        sel_valid1 = q_issue_instr1_valid;
        sel_pack0  = q_issue_instr0_pack;
        sel_pack1  = q_issue_instr1_pack;
        if (load_wake_up_failed_stall) begin
            sel_src    = ISSUE_SRC_WAKESTALL;
            sel_valid0 = ws_issue_instr0_valid;
            sel_valid1 = ws_issue_instr1_valid;
            sel_pack0  = ws_issue_instr0_pack;
            sel_pack1  = ws_issue_instr1_pack;
        end else if (replay_issue_first) begin
            sel_src    = ISSUE_SRC_REPLAY;
            sel_valid0 = rp_issue_instr0_valid;
            sel_valid1 = rp_issue_instr1_valid;
            sel_pack0  = rp_issue_instr0_pack;
            sel_pack1  = rp_issue_instr1_pack;
        end
    end

    // Killed queue ops are still granted: their ROB entries are being flushed anyway.
    always_comb begin
        q_issue_grant0 = 1'b0;
        q_issue_grant1 = 1'b0;
        if (capture && (sel_src == ISSUE_SRC_QUEUE)) begin
            q_issue_grant0 = q_issue_instr0_valid;
            q_issue_grant1 = q_issue_instr1_valid;
        end
    end

    int_issue_slot_reg u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .sel_valid (sel_valid0),
        .sel_pack  (sel_pack0),
        .hold      (hold),
        .squash    (squash),
        .flush     (recovery_flush_BCAST),
        .valid     (issue_instr0_valid),
        .pack      (issue_instr0_pack)
    );

    int_issue_slot_reg u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .sel_valid (sel_valid1),
        .sel_pack  (sel_pack1),
        .hold      (hold),
        .squash    (squash),
        .flush     (recovery_flush_BCAST),
        .valid     (issue_instr1_valid),
        .pack      (issue_instr1_pack)
    );

    // Source tag follows the packs, so it also updates on a squash cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_r <= ISSUE_SRC_QUEUE;
        end else if (!hold) begin
            src_r <= sel_src;
        end
    end

    assign issue_src = src_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            replay_cycle_cnt <= '0;
        end else if (capture && (sel_src != ISSUE_SRC_QUEUE) && (sel_valid0 || sel_valid1)
                     && (replay_cycle_cnt != CNT_MAX)) begin
            replay_cycle_cnt <= replay_cycle_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_int_issue_select_stage.sv
// Randomized self-checking bench for int_issue_select_stage against a behavioural model.
module tb_int_issue_select_stage;
    import Falco_pkg::*;

    localparam int unsigned CNT_W = 4;
    localparam int          CNT_SAT = 15;

    logic               clk;
    logic               rst;
    branch_flush_t      flush;
    logic               rs, md, wfs, pf, rif;
    logic               q_v0, q_v1, rp_v0, rp_v1, ws_v0, ws_v1;
    int_dispatch_pack_t q_p0, q_p1, rp_p0, rp_p1, ws_p0, ws_p1;
    logic               g0, g1;
    logic               o_v0, o_v1;
    int_dispatch_pack_t o_p0, o_p1;
    logic [1:0]         o_src;
    logic [CNT_W-1:0]   o_cnt;

    int n_checks = 0;
    int n_bad    = 0;

    logic               m_v[2];
    int_dispatch_pack_t m_p[2];
    int                 m_src;
    int                 m_cnt;

    int_issue_select_stage #(.CNT_W(CNT_W)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .recovery_flush_BCAST        (flush),
        .recovery_stall              (rs),
        .replay_muldiv_stall         (md),
        .load_wake_up_failed_stall   (wfs),
        .load_wake_up_predict_failed (pf),
        .replay_issue_first          (rif),
        .q_issue_instr0_valid        (q_v0),
        .q_issue_instr1_valid        (q_v1),
        .q_issue_instr0_pack         (q_p0),
        .q_issue_instr1_pack         (q_p1),
        .rp_issue_instr0_valid       (rp_v0),
        .rp_issue_instr1_valid       (rp_v1),
        .rp_issue_instr0_pack        (rp_p0),
        .rp_issue_instr1_pack        (rp_p1),
        .ws_issue_instr0_valid       (ws_v0),
        .ws_issue_instr1_valid       (ws_v1),
        .ws_issue_instr0_pack        (ws_p0),
        .ws_issue_instr1_pack        (ws_p1),
        .q_issue_grant0              (g0),
        .q_issue_grant1              (g1),
        .issue_instr0_valid          (o_v0),
        .issue_instr1_valid          (o_v1),
        .issue_instr0_pack           (o_p0),
        .issue_instr1_pack           (o_p1),
        .issue_src                   (o_src),
        .replay_cycle_cnt            (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int_dispatch_pack_t rand_pack(input int tag);
        int_dispatch_pack_t p;
        p.rob_tag = rob_tag_t'(tag);
        p.opcode  = 7'($urandom);
        p.prd     = 6'($urandom);
        p.prs1    = 6'($urandom);
        p.prs2    = 6'($urandom);
        p.imm     = 20'($urandom);
        return p;
    endfunction

    function automatic bit killed(input branch_flush_t f, input int_dispatch_pack_t p);
        return f.valid && (int'(p.rob_tag) >= int'(f.kill_from));
    endfunction

    task automatic idle();
        flush = '0;
        rs = 0; md = 0; wfs = 0; pf = 0; rif = 0;
        q_v0 = 0; q_v1 = 0; rp_v0 = 0; rp_v1 = 0; ws_v0 = 0; ws_v1 = 0;
        q_p0 = '0; q_p1 = '0; rp_p0 = '0; rp_p1 = '0; ws_p0 = '0; ws_p1 = '0;
    endtask

    task automatic model_reset();
        m_v[0] = 0; m_v[1] = 0; m_p[0] = '0; m_p[1] = '0; m_src = 0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        check("valid0", 64'(o_v0), 64'(m_v[0]));
        check("valid1", 64'(o_v1), 64'(m_v[1]));
        check("pack0", 64'(o_p0), 64'(m_p[0]));
        check("pack1", 64'(o_p1), 64'(m_p[1]));
        check("src", 64'(o_src), 64'(m_src));
        check("cnt", 64'(o_cnt), 64'(m_cnt));
    endtask

    // Apply the current inputs for one clock: check grants, advance the model, check outputs.
    task automatic cycle();
        logic               sv[2];
        int_dispatch_pack_t sp[2];
        int                 src;
        bit                 stall, sq;
        if (wfs) begin
            src = 2; sv[0] = ws_v0; sv[1] = ws_v1; sp[0] = ws_p0; sp[1] = ws_p1;
        end else if (rif) begin
            src = 1; sv[0] = rp_v0; sv[1] = rp_v1; sp[0] = rp_p0; sp[1] = rp_p1;
        end else begin
            src = 0; sv[0] = q_v0; sv[1] = q_v1; sp[0] = q_p0; sp[1] = q_p1;
        end
        stall = rs || md;
        sq    = pf && !stall;
        #1;
        check("grant0", 64'(g0), 64'(!stall && !pf && src == 0 && q_v0));
        check("grant1", 64'(g1), 64'(!stall && !pf && src == 0 && q_v1));
        if (stall) begin
            for (int i = 0; i < 2; i++) m_v[i] = m_v[i] && !killed(flush, m_p[i]);
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_p[i] = sp[i];
                m_v[i] = !sq && sv[i] && !killed(flush, sp[i]);
            end
            m_src = src;
            if (!sq && src != 0 && (sv[0] || sv[1]) && m_cnt < CNT_SAT) m_cnt++;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic randomize_inputs();
        flush.valid     = ($urandom_range(0, 3) == 0);
        flush.kill_from = 6'($urandom_range(0, 63));
        rs  = ($urandom_range(0, 9) == 0);
        md  = ($urandom_range(0, 9) == 0);
        wfs = ($urandom_range(0, 4) == 0);
        pf  = ($urandom_range(0, 9) == 0);
        rif = ($urandom_range(0, 2) == 0);
        q_v0 = 1'($urandom); q_v1 = 1'($urandom);
        rp_v0 = 1'($urandom); rp_v1 = 1'($urandom);
        ws_v0 = 1'($urandom); ws_v1 = 1'($urandom);
        q_p0 = rand_pack($urandom_range(0, 63)); q_p1 = rand_pack($urandom_range(0, 63));
        rp_p0 = rand_pack($urandom_range(0, 63)); rp_p1 = rand_pack($urandom_range(0, 63));
        ws_p0 = rand_pack($urandom_range(0, 63)); ws_p1 = rand_pack($urandom_range(0, 63));
    endtask

    initial begin
        rst = 1'b0;
        idle();
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Queue path
        idle();
        q_v0 = 1; q_v1 = 1; q_p0 = rand_pack(5); q_p1 = rand_pack(6);
        cycle();
        check("q_tag0", 64'(o_p0.rob_tag), 64'd5);
        check("q_tag1", 64'(o_p1.rob_tag), 64'd6);
        check("q_src", 64'(o_src), 64'(ISSUE_SRC_QUEUE));

        // Replay has priority over the queue
        idle();
        rif = 1; rp_v0 = 1; rp_v1 = 1; rp_p0 = rand_pack(3); rp_p1 = rand_pack(4);
        q_v0 = 1; q_v1 = 1; q_p0 = rand_pack(20); q_p1 = rand_pack(21);
        cycle();
        check("rp_tag0", 64'(o_p0.rob_tag), 64'd3);
        check("rp_tag1", 64'(o_p1.rob_tag), 64'd4);
        check("rp_src", 64'(o_src), 64'(ISSUE_SRC_REPLAY));
        check("rp_cnt", 64'(o_cnt), 64'd1);

        // Wake-stall beats replay, partial pair
        idle();
        wfs = 1; rif = 1; ws_v0 = 1; ws_p0 = rand_pack(7); ws_p1 = rand_pack(8);
        rp_v0 = 1; rp_v1 = 1; q_v0 = 1; q_v1 = 1;
        cycle();
        check("ws_v0", 64'(o_v0), 64'd1);
        check("ws_v1", 64'(o_v1), 64'd0);
        check("ws_tag0", 64'(o_p0.rob_tag), 64'd7);
        check("ws_src", 64'(o_src), 64'(ISSUE_SRC_WAKESTALL));

        // Hold with a branch kill of tags >= 10
        idle();
        q_v0 = 1; q_v1 = 1; q_p0 = rand_pack(9); q_p1 = rand_pack(12);
        cycle();
        rs = 1; flush.valid = 1; flush.kill_from = 6'd10;
        q_p0 = rand_pack(30); q_p1 = rand_pack(31);
        repeat (3) cycle();
        check("hold_v0", 64'(o_v0), 64'd1);
        check("hold_tag0", 64'(o_p0.rob_tag), 64'd9);
        check("hold_v1", 64'(o_v1), 64'd0);
        check("hold_cnt", 64'(o_cnt), 64'd2);

        // Squash
        idle();
        pf = 1; q_v0 = 1; q_v1 = 1; q_p0 = rand_pack(1); q_p1 = rand_pack(2);
        cycle();
        check("sq_v0", 64'(o_v0), 64'd0);
        check("sq_v1", 64'(o_v1), 64'd0);

        // Random traffic
        repeat (400) begin
            randomize_inputs();
            cycle();
        end

        // Saturation
        idle();
        rif = 1; rp_v0 = 1; rp_p0 = rand_pack(11); rp_p1 = rand_pack(12);
        repeat (18) cycle();
        check("sat_cnt", 64'(o_cnt), 64'(CNT_SAT));
        repeat (3) cycle();
        check("sat_hold_cnt", 64'(o_cnt), 64'(CNT_SAT));

        // Async reset in the middle of a stall
        idle();
        q_v0 = 1; q_v1 = 1; q_p0 = rand_pack(40); q_p1 = rand_pack(41);
        cycle();
        rs = 1;
        cycle();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #3;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
